hpm_snapshot_sampler: RTL

// Initiator on the perf-counter SRAM-like CSR port (addr/we/wdata/rdata). Periodically, or on a software

---
 rtl/hpm_snapshot_sampler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hpm_snapshot_sampler.sv
// Sweeps the HPM counters over the shared CSR port and streams each 64-bit value out on valid/ready.
// 3 cycles per word unstalled (4 when XLEN==32); snap_ready_i low holds the word with the port released.
module hpm_snapshot_sampler #(
    parameter int          NumCounters = 6,
    parameter int          XLEN        = 64,
    parameter logic [11:0] CntBase     = 12'hB03,
    parameter logic [11:0] CntBaseH    = 12'hB83
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic [31:0]                    period_i,
    input  logic                           trigger_i,
    input  logic                           clear_on_read_i,
    output logic                           perf_req_o,
    input  logic                           perf_gnt_i,
    output logic [11:0]                    perf_addr_o,
    output logic                           perf_we_o,
    output logic [XLEN-1:0]                perf_wdata_o,
    input  logic [XLEN-1:0]                perf_rdata_i,
    output logic                           snap_valid_o,
    input  logic                           snap_ready_i,
    output logic [$clog2(NumCounters)-1:0] snap_idx_o,
    output logic [63:0]                    snap_data_o,
    output logic                           snap_last_o,
    output logic                           busy_o,
    output logic [15:0]                    overrun_cnt_o
);
    localparam int              IdxW    = $clog2(NumCounters);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCounters - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_LO,
        S_RD_HI,
        S_PUSH
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     timer_q;
    logic            timer_fire;
    logic            start;
    logic [IdxW-1:0] idx_q;
    logic [63:0]     data_q;
    logic [63:0]     rdata_ext;
    logic            clr_q;
    logic            hi_pend_q;
    logic [15:0]     overrun_q;
    logic            is_last;

    assign timer_fire = enable_i && (period_i != 32'd0) && (timer_q == period_i - 32'd1);
    assign start      = timer_fire || trigger_i;
    assign is_last    = (idx_q == LastIdx);
    assign rdata_ext  = 64'(perf_rdata_i);

    // Timer keeps running through sweeps so the sampling cadence never drifts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (!enable_i || period_i == 32'd0 || timer_fire) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // After losing the grant mid-word, resume at the half still owed so a cleared low half is not re-read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_REQ;
            S_REQ:   if (perf_gnt_i) state_d = hi_pend_q ? S_RD_HI : S_RD_LO;
            S_RD_LO: begin
                if (!perf_gnt_i)      state_d = S_REQ;
                else if (XLEN == 32)  state_d = S_RD_HI;
                else                  state_d = S_PUSH;
            end
            S_RD_HI: state_d = perf_gnt_i ? S_PUSH : S_REQ;
            S_PUSH:  if (snap_ready_i) state_d = is_last ? S_IDLE : S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        perf_req_o   = 1'b0;
        perf_addr_o  = '0;
        perf_we_o    = 1'b0;
        snap_valid_o = 1'b0;
        snap_last_o  = 1'b0;
        case (state_q)
            S_REQ: perf_req_o = 1'b1;
            S_RD_LO: begin
                perf_req_o  = 1'b1;
                perf_addr_o = CntBase + 12'(idx_q);
                perf_we_o   = clr_q && perf_gnt_i;
            end
            S_RD_HI: begin
                perf_req_o  = 1'b1;
                perf_addr_o = CntBaseH + 12'(idx_q);
                perf_we_o   = clr_q && perf_gnt_i;
            end
            S_PUSH: begin
                snap_valid_o = 1'b1;
                snap_last_o  = is_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            data_q    <= '0;
            clr_q     <= 1'b0;
            hi_pend_q <= 1'b0;
            overrun_q <= '0;
        end else begin
            if (start) begin
                if (state_q == S_IDLE) begin
                    clr_q <= clear_on_read_i;
                    idx_q <= '0;
                end else if (overrun_q != 16'hFFFF) begin
                    overrun_q <= overrun_q + 16'd1;
                end
            end
            if (perf_gnt_i && state_q == S_RD_LO) begin
                if (XLEN == 32) begin
                    data_q[31:0] <= rdata_ext[31:0];
                    hi_pend_q    <= 1'b1;
                end else begin
                    data_q <= rdata_ext;
                end
            end
            if (perf_gnt_i && state_q == S_RD_HI) begin
                data_q[63:32] <= rdata_ext[31:0];
                hi_pend_q     <= 1'b0;
            end
            if (state_q == S_PUSH && snap_ready_i && !is_last) begin
                idx_q <= idx_q + IdxW'(1);
            end
        end
    end

    assign perf_wdata_o  = '0;
    assign snap_idx_o    = idx_q;
    assign snap_data_o   = data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign overrun_cnt_o = overrun_q;

endmodule
